memory_tester: RTL and testbench

Built-in self-test initiator for the 64×16 single-port `memory` block.
- On `start`, it writes a seed-derived pattern to every word, reads it back and compares, then repeats with the bitwise-inverted pattern.
- It reports an error count, the first failing address, and pass/fail.
- It sits between the top-level control (button/switch logic) and the memory port, driving `write`, `step`, `address` and `din`, and sampling `dout`.

---
 rtl/memory_tester_pkg.sv | 32 +++
 rtl/memory_tester.sv | 101 ++++++++++
 tb/tb_memory_tester.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/memory_tester_pkg.sv
// Shared types, default sizes and test-pattern function for the memory BIST.
// Imported by the memory_tester top and reusable by any verification code.
package memory_tester_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_WRI  = 3'd3,
    ST_RDI  = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  // P(seed, a) = seed ^ R(a), bit i of R(a) = a[i mod ADDR_W];
  // inverted for the second pass. Default widths only.
  function automatic logic [DATA_W_DEF-1:0] pattern(
    input logic [DATA_W_DEF-1:0] seed,
    input logic [ADDR_W_DEF-1:0] a,
    input logic                  invert
  );
    logic [DATA_W_DEF-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_W_DEF; i++) begin
      r[i] = a[i % ADDR_W_DEF];
    end
    pattern = invert ? ~(seed ^ r) : (seed ^ r);
  endfunction

endpackage

// File: rtl/memory_tester.sv
// Built-in self-test initiator: writes P then ~P to every word, reads back.
// Ports: clk/reset/start/advance/seed in; mem_* memory port; busy/done/pass/err results.
module memory_tester
  import memory_tester_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              advance,
  input  logic [DATA_W-1:0] seed,
  output logic              mem_write,
  output logic              mem_step,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W+1:0] err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  state_t            state;
  logic [DATA_W-1:0] seed_q;
  logic [DATA_W-1:0] ramp;
  logic [DATA_W-1:0] expect_pat;
  logic              inv_phase;
  logic              wr_phase;
  logic              rd_phase;
  logic              last_addr;
  logic              mismatch;

  // Address replicated across the data word: bit i = addr[i mod ADDR_W].
  always_comb begin
    ramp = '0;
    for (int i = 0; i < DATA_W; i++) begin
      ramp[i] = mem_addr[i % ADDR_W];
    end
  end

  assign inv_phase  = (state == ST_WRI) || (state == ST_RDI);
  assign wr_phase   = (state == ST_WR) || (state == ST_WRI);
  assign rd_phase   = (state == ST_RD) || (state == ST_RDI);
  assign expect_pat = inv_phase ? ~(seed_q ^ ramp) : (seed_q ^ ramp);
  assign last_addr  = &mem_addr;
  assign mismatch   = rd_phase && advance && (mem_dout != expect_pat);

  assign mem_write = wr_phase;
  assign mem_step  = wr_phase && advance;
  assign mem_din   = wr_phase ? expect_pat : '0;
  assign busy      = wr_phase || rd_phase;
  assign done      = (state == ST_DONE);
  assign pass      = done && (err_count == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      mem_addr       <= '0;
      seed_q         <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state          <= ST_WR;
            mem_addr       <= '0;
            seed_q         <= seed;
            err_count      <= '0;
            first_err_addr <= '0;
          end
        end
        ST_WR, ST_RD, ST_WRI, ST_RDI: begin
          if (advance) begin
            mem_addr <= mem_addr + 1'b1;
            if (last_addr) begin
              unique case (state)
                ST_WR:   state <= ST_RD;
                ST_RD:   state <= ST_WRI;
                ST_WRI:  state <= ST_RDI;
                default: state <= ST_DONE;
              endcase
            end
          end
          if (mismatch) begin
            if (err_count == '0) first_err_addr <= mem_addr;
            if (err_count != '1) err_count <= err_count + 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          mem_addr <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_tester.sv
// Directed bench for memory_tester with a behavioural 64x16 memory
// and simple read-data fault injection.
module tb_memory_tester;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        advance;
  logic [15:0] seed;
  logic        mem_write;
  logic        mem_step;
  logic [5:0]  mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;
  logic        busy;
  logic        done;
  logic        pass;
  logic [7:0]  err_count;
  logic [5:0]  first_err_addr;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] mem [64];
  int          fault = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_write && mem_step) mem[mem_addr] <= mem_din;

  always_comb begin
    mem_dout = mem[mem_addr];
    if (fault == 2) mem_dout = 16'h0000;
    else if (fault == 1 && mem_addr == 6'd12) mem_dout = mem[mem_addr] | 16'h0001;
  end

  memory_tester dut (
    .clk(clk), .reset(reset), .start(start), .advance(advance),
    .seed(seed), .mem_write(mem_write), .mem_step(mem_step),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr)
  );

  // Accept start at the next edge; leaves time at edge+1.
  task automatic kick(input logic [15:0] s);
    seed  = s;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count busy cycles at full speed (bounded).
  task automatic run_busy(output int n);
    n = 0;
    while (busy && n < 3000) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; advance = 1'b1; seed = 16'h0;
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    vectors++;
    if ({mem_write, mem_step, busy, done, pass} !== 5'b0 ||
        mem_addr !== 6'd0 || mem_din !== 16'h0 ||
        err_count !== 8'd0 || first_err_addr !== 6'd0) begin
      miscompares++;
      $display("FAIL reset: w=%b s=%b b=%b d=%b p=%b a=%0d din=%h e=%0d f=%0d, required all zero",
               mem_write, mem_step, busy, done, pass, mem_addr, mem_din, err_count, first_err_addr);
    end
  endtask

  task automatic test_full_run;
    int n;
    kick(16'hA5C3);
    run_busy(n);
    vectors++;
    if (n !== 256) begin
      miscompares++; $display("FAIL full_len: %0d cycles, required 256", n);
    end
    vectors++;
    if (done !== 1'b1 || pass !== 1'b1 || err_count !== 8'd0 || first_err_addr !== 6'd0) begin
      miscompares++;
      $display("FAIL full_result: d=%b p=%b e=%0d f=%0d, required 1 1 0 0",
               done, pass, err_count, first_err_addr);
    end
    vectors++;
    if (mem[5] !== 16'h0B79 || mem[0] !== 16'h5A3C || mem[63] !== 16'hA5C3) begin
      miscompares++;
      $display("FAIL full_mem: m5=%h m0=%h m63=%h, required 0b79 5a3c a5c3",
               mem[5], mem[0], mem[63]);
    end
  endtask

  task automatic test_stuck_bit;
    int n;
    fault = 1;
    kick(16'hA5C3);
    run_busy(n);
    fault = 0;
    vectors++;
    if (err_count !== 8'd1 || first_err_addr !== 6'd12 || pass !== 1'b0 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL stuck_bit: e=%0d f=%0d p=%b d=%b, required 1 12 0 1",
               err_count, first_err_addr, pass, done);
    end
  endtask

  task automatic test_stuck_zero;
    int n;
    fault = 2;
    kick(16'hA5C3);
    run_busy(n);
    fault = 0;
    vectors++;
    if (err_count !== 8'd128 || first_err_addr !== 6'd0 || pass !== 1'b0) begin
      miscompares++;
      $display("FAIL stuck_zero: e=%0d f=%0d p=%b, required 128 0 0",
               err_count, first_err_addr, pass);
    end
  endtask

  task automatic test_slow_advance;
    int n = 0;
    int bad_step = 0;
    kick(16'h1234);
    advance = 1'b0;
    while (busy && n < 3000) begin
      advance = (n % 3 == 2);
      #1;
      if (!advance && mem_step) bad_step++;
      n++;
      @(posedge clk); #1;
    end
    advance = 1'b1;
    vectors++;
    if (n !== 768) begin
      miscompares++; $display("FAIL slow_len: %0d cycles, required 768", n);
    end
    vectors++;
    if (bad_step !== 0) begin
      miscompares++; $display("FAIL slow_step: %0d stray steps, required 0", bad_step);
    end
    vectors++;
    if (done !== 1'b1 || pass !== 1'b1 || err_count !== 8'd0) begin
      miscompares++;
      $display("FAIL slow_result: d=%b p=%b e=%0d, required 1 1 0", done, pass, err_count);
    end
  endtask

  task automatic test_reset_midrun;
    int n;
    fault = 2;
    kick(16'hA5C3);
    repeat (99) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b1 || err_count === 8'd0) begin
      miscompares++;
      $display("FAIL mid_busy: b=%b e=%0d, required busy with errors", busy, err_count);
    end
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0; fault = 0;
    vectors++;
    if ({mem_write, mem_step, busy, done, pass} !== 5'b0 ||
        mem_addr !== 6'd0 || mem_din !== 16'h0 ||
        err_count !== 8'd0 || first_err_addr !== 6'd0) begin
      miscompares++;
      $display("FAIL mid_reset: b=%b d=%b a=%0d din=%h e=%0d f=%0d, required zeros",
               busy, done, mem_addr, mem_din, err_count, first_err_addr);
    end
    kick(16'h0000);
    run_busy(n);
    vectors++;
    if (n !== 256 || pass !== 1'b1 || mem[5] !== 16'hAEBA) begin
      miscompares++;
      $display("FAIL seed0_run: n=%0d p=%b m5=%h, required 256 1 aeba", n, pass, mem[5]);
    end
  endtask

  task automatic test_start_while_busy;
    int n;
    kick(16'hA5C3);
    repeat (49) @(posedge clk);
    #1;
    seed = 16'hFFFF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    run_busy(n);
    vectors++;
    if (n !== 206 || pass !== 1'b1 || mem[5] !== 16'h0B79) begin
      miscompares++;
      $display("FAIL busy_start: rest=%0d p=%b m5=%h, required 206 1 0b79", n, pass, mem[5]);
    end
    kick(16'h0000);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b1 || mem_addr !== 6'd0) begin
      miscompares++;
      $display("FAIL restart: d=%b b=%b a=%0d, required 0 1 0", done, busy, mem_addr);
    end
    run_busy(n);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0;
    test_reset;
    test_full_run;
    test_stuck_bit;
    test_stuck_zero;
    test_slow_advance;
    test_reset_midrun;
    test_start_while_busy;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
